// File: rtl/branch_resolve_ctrl_if.sv
// Branch-resolution bus: execute-stage request, shared comparator hookup,
// resolution results and the PC-redirect handshake to fetch.
interface branch_resolve_ctrl_if #(
    parameter int XLEN = 32
);
    logic            br_valid;
    logic            br_ready;
    logic [2:0]      br_funct3;
    logic            br_is_jal;
    logic            br_is_jalr;
    logic [XLEN-1:0] br_pc;
    logic [XLEN-1:0] br_imm;
    logic [XLEN-1:0] br_rs1;
    logic [XLEN-1:0] br_rs2;
    logic            br_pred_taken;

    logic [XLEN-1:0] cmp_rs1;
    logic [XLEN-1:0] cmp_rs2;
    logic            cmp_op;
    logic            cmp_eq;
    logic            cmp_lt;

    logic            res_valid;
    logic            res_taken;
    logic            res_mispredict;
    logic [XLEN-1:0] res_link;
    logic            res_excp;

    logic            redir_valid;
    logic            redir_ready;
    logic [XLEN-1:0] redir_pc;
    logic            flush;

    // Pipeline side: issues requests, hosts the comparator, consumes redirects.
    modport master (
        output br_valid, br_funct3, br_is_jal, br_is_jalr, br_pc, br_imm,
               br_rs1, br_rs2, br_pred_taken, cmp_eq, cmp_lt, redir_ready,
        input  br_ready, cmp_rs1, cmp_rs2, cmp_op, res_valid, res_taken,
               res_mispredict, res_link, res_excp, redir_valid, redir_pc, flush
    );

    modport slave (
        input  br_valid, br_funct3, br_is_jal, br_is_jalr, br_pc, br_imm,
               br_rs1, br_rs2, br_pred_taken, cmp_eq, cmp_lt, redir_ready,
        output br_ready, cmp_rs1, cmp_rs2, cmp_op, res_valid, res_taken,
               res_mispredict, res_link, res_excp, redir_valid, redir_pc, flush
    );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// Execute-stage branch/jump resolver: drives the shared comparator, decides
// direction and target, and redirects fetch on mispredict.
module branch_resolve_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    branch_resolve_ctrl_if.slave  bus,
    output logic [CNT_W-1:0]      branch_cnt,
    output logic [CNT_W-1:0]      mispredict_cnt
);
    typedef enum logic [1:0] {IDLE, CMP, REDIRECT} state_t;

    localparam logic [XLEN-1:0] INSN_BYTES = XLEN'(4);

    state_t          state, state_nxt;

    logic [XLEN-1:0] pc_q, imm_q, rs1_q, rs2_q;
    logic [2:0]      funct3_q;
    logic            is_jal_q, is_jalr_q, pred_q, cmp_op_q;

    logic            taken, illegal, excp, mispredict;
    logic [XLEN-1:0] target, link, jalr_sum;

    // Decision logic, only meaningful while in CMP.
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        taken    = 1'b0;
        illegal  = 1'b0;
        link     = pc_q + INSN_BYTES;
        jalr_sum = rs1_q + imm_q;
        target   = pc_q + imm_q;
        if (is_jalr_q) begin
            // JALR wins when both jump flags are set.
            target = {jalr_sum[XLEN-1:1], 1'b0};
            taken  = 1'b1;
        end else if (is_jal_q) begin
            taken = 1'b1;
        end else begin
            unique case (funct3_q)
                3'b000:  taken = bus.cmp_eq;
                3'b001:  taken = !bus.cmp_eq;
                3'b100:  taken = bus.cmp_lt;
                3'b101:  taken = !bus.cmp_lt;
                3'b110:  taken = bus.cmp_lt;
                3'b111:  taken = !bus.cmp_lt;
                default: illegal = 1'b1;
            endcase
        end
        excp       = illegal | (taken & target[1]);
        mispredict = !excp & ((taken != pred_q) | (is_jalr_q & taken));
    end

    always_comb begin
        state_nxt       = state;
        bus.br_ready    = 1'b0;
        bus.redir_valid = 1'b0;
        unique case (state)
            IDLE: begin
                bus.br_ready = 1'b1;
                if (bus.br_valid) state_nxt = CMP;
            end
            CMP:  state_nxt = mispredict ? REDIRECT : IDLE;
            REDIRECT: begin
                bus.redir_valid = 1'b1;
                if (bus.redir_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state always uses non-blocking assignments.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: operand latches are reset too, so the comparator sees zeros after reset.
        if (!rst_n) begin
            pc_q               <= '0;
            imm_q              <= '0;
            rs1_q              <= '0;
            rs2_q              <= '0;
            funct3_q           <= '0;
            is_jal_q           <= 1'b0;
            is_jalr_q          <= 1'b0;
            pred_q             <= 1'b0;
            cmp_op_q           <= 1'b0;
            bus.res_valid      <= 1'b0;
            bus.res_taken      <= 1'b0;
            bus.res_mispredict <= 1'b0;
            bus.res_excp       <= 1'b0;
            bus.res_link       <= '0;
            bus.redir_pc       <= '0;
            bus.flush          <= 1'b0;
            branch_cnt         <= '0;
            mispredict_cnt     <= '0;
        end else begin
            bus.res_valid <= 1'b0;
            bus.flush     <= 1'b0;
            unique case (state)
                IDLE: if (bus.br_valid) begin
                    pc_q      <= bus.br_pc;
                    imm_q     <= bus.br_imm;
                    rs1_q     <= bus.br_rs1;
                    rs2_q     <= bus.br_rs2;
                    funct3_q  <= bus.br_funct3;
                    is_jal_q  <= bus.br_is_jal;
                    is_jalr_q <= bus.br_is_jalr;
                    pred_q    <= bus.br_pred_taken;
                    // Signed compare for BEQ/BNE/BLT/BGE; unsigned otherwise.
                    cmp_op_q  <= !(bus.br_is_jal | bus.br_is_jalr) &
                                 (bus.br_funct3[2:1] == 2'b00 || bus.br_funct3[2:1] == 2'b10);
                end
                CMP: begin
                    bus.res_valid      <= 1'b1;
                    bus.res_taken      <= taken;
                    bus.res_mispredict <= mispredict;
                    bus.res_excp       <= excp;
                    bus.res_link       <= link;
                    if (mispredict) bus.redir_pc <= taken ? target : link;
                    if (branch_cnt != '1) branch_cnt <= branch_cnt + CNT_W'(1);
                    if (mispredict && mispredict_cnt != '1)
                        mispredict_cnt <= mispredict_cnt + CNT_W'(1);
                end
                REDIRECT: if (bus.redir_ready) bus.flush <= 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.cmp_rs1 = rs1_q;
    assign bus.cmp_rs2 = rs2_q;
    assign bus.cmp_op  = cmp_op_q;
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: vector table with scoreboard,
// plus hand-written backpressure, async reset and counter saturation sequences.
module tb_branch_resolve_ctrl;
    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic [CNT_W-1:0] branch_cnt, mispredict_cnt;

    branch_resolve_ctrl_if #(.XLEN(XLEN)) bus ();

    branch_resolve_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .branch_cnt     (branch_cnt),
        .mispredict_cnt (mispredict_cnt)
    );

    always #5 clk = ~clk;

    // Model of the shared comparator that lives outside the controller.
    always_comb begin
        bus.cmp_eq = (bus.cmp_rs1 == bus.cmp_rs2);
        bus.cmp_lt = bus.cmp_op ? ($signed(bus.cmp_rs1) < $signed(bus.cmp_rs2))
                                : (bus.cmp_rs1 < bus.cmp_rs2);
    end

    typedef struct {
        logic [2:0]  funct3;
        logic        is_jal;
        logic        is_jalr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        pred;
        logic        exp_taken;
        logic        exp_misp;
        logic        exp_excp;
        logic        exp_cmp_op;
        logic [31:0] exp_redir;
    } vec_t;

    vec_t vecs[14];
    vec_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   exp_bcnt = 0;
    int   exp_mcnt = 0;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Drive one request at a negedge; returns at the negedge of the CMP cycle.
    task automatic issue(input vec_t v);
        check("br_ready_idle", bus.br_ready, 1'b1);
        bus.br_funct3     = v.funct3;
        bus.br_is_jal     = v.is_jal;
        bus.br_is_jalr    = v.is_jalr;
        bus.br_pc         = v.pc;
        bus.br_imm        = v.imm;
        bus.br_rs1        = v.rs1;
        bus.br_rs2        = v.rs2;
        bus.br_pred_taken = v.pred;
        bus.br_valid      = 1'b1;
        sb.push_back(v);
        @(negedge clk);
        bus.br_valid = 1'b0;
        bus.br_rs1   = 32'hDEAD_BEEF;
        check("br_ready_cmp", bus.br_ready, 1'b0);
        check("cmp_op", bus.cmp_op, v.exp_cmp_op);
        check("cmp_rs1", bus.cmp_rs1, v.rs1);
        check("cmp_rs2", bus.cmp_rs2, v.rs2);
    endtask

    task automatic expect_result(output vec_t e);
        int waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!bus.res_valid && waited < 8);
        check("res_valid", bus.res_valid, 1'b1);
        check("res_latency", waited, 1);
        e = sb.pop_front();
        if (exp_bcnt < CNT_MAX) exp_bcnt++;
        if (e.exp_misp && exp_mcnt < CNT_MAX) exp_mcnt++;
        check("res_taken", bus.res_taken, e.exp_taken);
        check("res_mispredict", bus.res_mispredict, e.exp_misp);
        check("res_excp", bus.res_excp, e.exp_excp);
        check("res_link", bus.res_link, e.pc + 32'd4);
        check("redir_valid", bus.redir_valid, e.exp_misp);
        check("br_ready_n2", bus.br_ready, !e.exp_misp);
        check("branch_cnt", branch_cnt, exp_bcnt);
        check("mispredict_cnt", mispredict_cnt, exp_mcnt);
        if (e.exp_misp) check("redir_pc", bus.redir_pc, e.exp_redir);
    endtask

    // Full transaction with redir_ready held high.
    task automatic run_vec(input vec_t v);
        vec_t e;
        issue(v);
        expect_result(e);
        @(negedge clk);
        check("res_valid_pulse", bus.res_valid, 1'b0);
        check("res_taken_hold", bus.res_taken, e.exp_taken);
        if (e.exp_misp) begin
            check("flush_on", bus.flush, 1'b1);
            check("redir_drop", bus.redir_valid, 1'b0);
            @(negedge clk);
            check("flush_off", bus.flush, 1'b0);
        end
        check("br_ready_after", bus.br_ready, 1'b1);
    endtask

    initial begin
        vec_t e;
        int   flush_seen;

        //        f3     jal   jalr  pc            imm           rs1           rs2           pred  tk    misp  excp  op    redir
        vecs[0]  = '{3'b000, 1'b0, 1'b0, 32'h100,      32'h20,       32'd5,        32'd5,        1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h120};
        vecs[1]  = '{3'b100, 1'b0, 1'b0, 32'h200,      32'h10,       32'hFFFFFFFF, 32'd1,        1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
        vecs[2]  = '{3'b110, 1'b0, 1'b0, 32'h200,      32'h10,       32'hFFFFFFFF, 32'd1,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{3'b000, 1'b0, 1'b1, 32'h40,       32'h0,        32'h203,      32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[4]  = '{3'b000, 1'b0, 1'b1, 32'h40,       32'h0,        32'h201,      32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h200};
        vecs[5]  = '{3'b001, 1'b0, 1'b0, 32'h300,      32'h40,       32'd3,        32'd3,        1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h304};
        vecs[6]  = '{3'b101, 1'b0, 1'b0, 32'h400,      32'hFFFFFFF0, 32'd1,        32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
        vecs[7]  = '{3'b111, 1'b0, 1'b0, 32'h400,      32'hFFFFFFF0, 32'd1,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[8]  = '{3'b000, 1'b1, 1'b0, 32'h500,      32'h100,      32'd0,        32'd0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h600};
        vecs[9]  = '{3'b000, 1'b1, 1'b0, 32'h500,      32'h100,      32'd0,        32'd0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[10] = '{3'b010, 1'b0, 1'b0, 32'h600,      32'h8,        32'd1,        32'd2,        1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[11] = '{3'b000, 1'b0, 1'b0, 32'h100,      32'h2,        32'd0,        32'd0,        1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0};
        vecs[12] = '{3'b000, 1'b1, 1'b1, 32'h80,       32'h11,       32'h1000,     32'd0,        1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1010};
        vecs[13] = '{3'b110, 1'b0, 1'b0, 32'hFFFFFFF0, 32'h20,       32'd1,        32'd2,        1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10};

        rst_n             = 1'b0;
        bus.br_valid      = 1'b0;
        bus.br_funct3     = '0;
        bus.br_is_jal     = 1'b0;
        bus.br_is_jalr    = 1'b0;
        bus.br_pc         = '0;
        bus.br_imm        = '0;
        bus.br_rs1        = '0;
        bus.br_rs2        = '0;
        bus.br_pred_taken = 1'b0;
        bus.redir_ready   = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_res_valid", bus.res_valid, 1'b0);
        check("rst_redir_valid", bus.redir_valid, 1'b0);
        check("rst_flush", bus.flush, 1'b0);
        check("rst_cmp_rs1", bus.cmp_rs1, 32'h0);
        check("rst_cmp_op", bus.cmp_op, 1'b0);
        check("rst_branch_cnt", branch_cnt, 4'h0);
        check("rst_br_ready", bus.br_ready, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Redirect backpressure with a competing request that must be ignored.
        bus.redir_ready = 1'b0;
        issue(vecs[0]);
        expect_result(e);
        bus.br_valid  = 1'b1;
        bus.br_funct3 = 3'b001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_redir_valid", bus.redir_valid, 1'b1);
            check("bp_redir_pc", bus.redir_pc, 32'h120);
            check("bp_br_ready", bus.br_ready, 1'b0);
            check("bp_res_valid", bus.res_valid, 1'b0);
            check("bp_flush", bus.flush, 1'b0);
        end
        bus.br_valid    = 1'b0;
        bus.redir_ready = 1'b1;
        flush_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.flush) flush_seen++;
        end
        check("bp_flush_count", flush_seen, 1);
        check("bp_branch_cnt", branch_cnt, exp_bcnt);
        check("bp_br_ready_end", bus.br_ready, 1'b1);

        // Asynchronous reset while holding a redirect.
        bus.redir_ready = 1'b0;
        issue(vecs[0]);
        expect_result(e);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("ar_redir_valid", bus.redir_valid, 1'b0);
        check("ar_branch_cnt", branch_cnt, 4'h0);
        check("ar_mispredict_cnt", mispredict_cnt, 4'h0);
        check("ar_cmp_rs1", bus.cmp_rs1, 32'h0);
        exp_bcnt = 0;
        exp_mcnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.redir_ready = 1'b1;
        @(negedge clk);
        check("ar_br_ready", bus.br_ready, 1'b1);
        check("ar_flush", bus.flush, 1'b0);
        check("ar_res_valid", bus.res_valid, 1'b0);

        // Counter saturation: 17 mispredicting branches from a fresh reset.
        for (int i = 0; i < 17; i++) run_vec(vecs[0]);
        check("sat_branch_cnt", branch_cnt, 4'hF);
        check("sat_mispredict_cnt", mispredict_cnt, 4'hF);
        run_vec(vecs[10]);
        check("sat_hold", branch_cnt, 4'hF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
